// File: rtl/fabric_lane_array.sv
// LANES-wide programmable register lane array with config, scan and register chains.
// Optional FABRIC_SYNC_CLEAR_EN adds the fabric_sclr synchronous clear input.
module fabric_lane_array #(
    parameter int LANES = 2,
    parameter int CFG_W = 4
) (
    input  logic             fabric_clk,
    input  logic             fabric_reset,
    input  logic             Test_en,
    input  logic             cfg_en,
    input  logic             ccff_head,
    output logic             ccff_tail,
    input  logic [LANES-1:0] frac_logic_out,
    input  logic             fabric_reg_in,
    input  logic             fabric_sc_in,
    input  logic             fabric_ce,
`ifdef FABRIC_SYNC_CLEAR_EN
    input  logic             fabric_sclr,
`endif
    output logic [LANES-1:0] fabric_out,
    output logic             fabric_reg_out,
    output logic             fabric_sc_out
);

    localparam int CFG_N = LANES * CFG_W;

    typedef enum logic [1:0] {
        DSEL_LUT    = 2'b00,
        DSEL_CHAIN  = 2'b01,
        DSEL_TOGGLE = 2'b10,
        DSEL_HOLD   = 2'b11
    } dsel_e;

    logic [CFG_N-1:0] cfg;
    logic [LANES-1:0] q;
    logic [LANES-1:0] chain_src;
    logic [LANES-1:0] scan_src;
    logic [LANES-1:0] norm_nxt;
    logic [LANES-1:0] omux;
    logic             sclr;

`ifdef FABRIC_SYNC_CLEAR_EN
    assign sclr = fabric_sclr;
`else
    assign sclr = 1'b0;
`endif

    // Neighbour sources come from pre-edge Q, so chain and scan are true shifts.
    always_comb begin
        chain_src    = '0;
        scan_src     = '0;
        chain_src[0] = fabric_reg_in;
        scan_src[0]  = fabric_sc_in;
        for (int i = 1; i < LANES; i++) begin
            chain_src[i] = q[i-1];
            scan_src[i]  = q[i-1];
        end
    end

    always_comb begin
        logic [3:0] lane;
        norm_nxt = q;
        omux     = '0;
        lane     = '0;
        for (int i = 0; i < LANES; i++) begin
            lane    = cfg[i*CFG_W +: CFG_W];
            omux[i] = lane[2];
            if (!(lane[3] && !fabric_ce)) begin
                unique case (dsel_e'(lane[1:0]))
                    DSEL_LUT:    norm_nxt[i] = frac_logic_out[i];
                    DSEL_CHAIN:  norm_nxt[i] = chain_src[i];
                    DSEL_TOGGLE: norm_nxt[i] = q[i] ^ frac_logic_out[i];
                    DSEL_HOLD:   norm_nxt[i] = q[i];
                endcase
            end
        end
    end

    always_ff @(posedge fabric_clk or posedge fabric_reset) begin
        if (fabric_reset) begin
            cfg <= '0;
            q   <= '0;
        end else if (cfg_en) begin
            cfg <= {cfg[CFG_N-2:0], ccff_head};
        end else if (sclr) begin
            q <= '0;
        end else if (Test_en) begin
            q <= scan_src;
        end else begin
            q <= norm_nxt;
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            fabric_out[i] = omux[i] ? q[i] : frac_logic_out[i];
        end
    end

    assign ccff_tail      = cfg[CFG_N-1];
    assign fabric_reg_out = q[LANES-1];
    assign fabric_sc_out  = q[LANES-1];

endmodule

// File: tb/tb_fabric_lane_array.sv
// Directed bench for fabric_lane_array with LANES=2.
// Define FABRIC_SYNC_CLEAR_EN to also exercise the synchronous clear.
module tb_fabric_lane_array;

    logic       fabric_clk = 1'b0;
    logic       fabric_reset = 1'b0;
    logic       Test_en = 1'b0;
    logic       cfg_en = 1'b0;
    logic       ccff_head = 1'b0;
    logic       ccff_tail;
    logic [1:0] frac_logic_out = 2'b00;
    logic       fabric_reg_in = 1'b0;
    logic       fabric_sc_in = 1'b0;
    logic       fabric_ce = 1'b0;
`ifdef FABRIC_SYNC_CLEAR_EN
    logic       fabric_sclr = 1'b0;
`endif
    logic [1:0] fabric_out;
    logic       fabric_reg_out;
    logic       fabric_sc_out;

    int total = 0;
    int bad = 0;

    fabric_lane_array #(.LANES(2), .CFG_W(4)) dut (
        .fabric_clk     (fabric_clk),
        .fabric_reset   (fabric_reset),
        .Test_en        (Test_en),
        .cfg_en         (cfg_en),
        .ccff_head      (ccff_head),
        .ccff_tail      (ccff_tail),
        .frac_logic_out (frac_logic_out),
        .fabric_reg_in  (fabric_reg_in),
        .fabric_sc_in   (fabric_sc_in),
        .fabric_ce      (fabric_ce),
`ifdef FABRIC_SYNC_CLEAR_EN
        .fabric_sclr    (fabric_sclr),
`endif
        .fabric_out     (fabric_out),
        .fabric_reg_out (fabric_reg_out),
        .fabric_sc_out  (fabric_sc_out)
    );

    always #5 fabric_clk = ~fabric_clk;

    task automatic tick();
        @(posedge fabric_clk);
        #1;
    endtask

    task automatic do_reset();
        fabric_reset = 1'b1;
        #2;
        fabric_reset = 1'b0;
    endtask

    // Shift an 8-bit word MSB-first: w[7:4] lands in lane 1, w[3:0] in lane 0.
    task automatic load_cfg(input logic [7:0] w);
        cfg_en = 1'b1;
        for (int b = 7; b >= 0; b--) begin
            ccff_head = w[b];
            tick();
        end
        cfg_en    = 1'b0;
        ccff_head = 1'b0;
    endtask

    task automatic test_reset();
        frac_logic_out = 2'b10;
        fabric_reset   = 1'b1;
        #1;
        total++;
        if (fabric_out !== 2'b10) begin
            bad++;
            $display("FAIL reset_out got=%b exp=10", fabric_out);
        end
        total++;
        if (fabric_reg_out !== 1'b0 || fabric_sc_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_reg got=%b%b exp=00", fabric_reg_out, fabric_sc_out);
        end
        total++;
        if (ccff_tail !== 1'b0) begin
            bad++;
            $display("FAIL reset_tail got=%b exp=0", ccff_tail);
        end
        fabric_reset = 1'b0;
        tick();
        for (int v = 0; v < 4; v++) begin
            frac_logic_out = 2'(v);
            #1;
            total++;
            if (fabric_out !== 2'(v)) begin
                bad++;
                $display("FAIL passthru got=%b exp=%b", fabric_out, 2'(v));
            end
        end
    endtask

    task automatic test_cfg_chain();
        logic [7:0] pat;
        pat = 8'b0110_0001;
        do_reset();
        frac_logic_out = 2'b11;
        fabric_ce      = 1'b1;
        Test_en        = 1'b1;
        fabric_sc_in   = 1'b1;
        cfg_en         = 1'b1;
        for (int b = 7; b >= 0; b--) begin
            ccff_head = pat[b];
            tick();
            total++;
            if (fabric_sc_out !== 1'b0) begin
                bad++;
                $display("FAIL cfg_q_hold got=%b exp=0", fabric_sc_out);
            end
        end
        total++;
        if (fabric_out !== 2'b01) begin
            bad++;
            $display("FAIL cfg_apply got=%b exp=01", fabric_out);
        end
        ccff_head = 1'b0;
        for (int k = 0; k < 8; k++) begin
            total++;
            if (ccff_tail !== pat[7-k]) begin
                bad++;
                $display("FAIL cfg_tail k=%0d got=%b exp=%b", k, ccff_tail, pat[7-k]);
            end
            tick();
        end
        cfg_en  = 1'b0;
        Test_en = 1'b0;
        total++;
        if (fabric_out !== 2'b11 || fabric_sc_out !== 1'b0) begin
            bad++;
            $display("FAIL cfg_flushed got=%b/%b exp=11/0", fabric_out, fabric_sc_out);
        end
    endtask

    task automatic test_reg_chain();
        logic [1:0] exp_out [3];
        logic       exp_reg [3];
        exp_out = '{2'b01, 2'b10, 2'b00};
        exp_reg = '{1'b0, 1'b1, 1'b0};
        do_reset();
        frac_logic_out = 2'b00;
        fabric_ce      = 1'b0;
        load_cfg(8'b0101_0101);
        for (int e = 0; e < 3; e++) begin
            fabric_reg_in = (e == 0);
            tick();
            total++;
            if (fabric_out !== exp_out[e] || fabric_reg_out !== exp_reg[e]) begin
                bad++;
                $display("FAIL chain edge=%0d got=%b/%b exp=%b/%b",
                         e + 1, fabric_out, fabric_reg_out, exp_out[e], exp_reg[e]);
            end
        end
    endtask

    task automatic test_toggle();
        logic ce_seq [4];
        logic exp_q  [4];
        ce_seq = '{1'b1, 1'b0, 1'b1, 1'b1};
        exp_q  = '{1'b1, 1'b1, 1'b0, 1'b1};
        do_reset();
        frac_logic_out = 2'b01;
        load_cfg(8'b0111_1110);
        for (int e = 0; e < 4; e++) begin
            fabric_ce = ce_seq[e];
            tick();
            total++;
            if (fabric_out !== {1'b0, exp_q[e]}) begin
                bad++;
                $display("FAIL toggle edge=%0d got=%b exp=0%b", e + 1, fabric_out, exp_q[e]);
            end
        end
        fabric_ce = 1'b0;
    endtask

    task automatic test_scan();
        do_reset();
        frac_logic_out = 2'b01;
        fabric_ce      = 1'b0;
        load_cfg(8'b0111_1110);
        Test_en      = 1'b1;
        fabric_sc_in = 1'b1;
        tick();
        total++;
        if (fabric_sc_out !== 1'b0 || fabric_out !== 2'b01) begin
            bad++;
            $display("FAIL scan_e1 got=%b/%b exp=0/01", fabric_sc_out, fabric_out);
        end
        fabric_sc_in = 1'b0;
        tick();
        total++;
        if (fabric_sc_out !== 1'b1 || fabric_reg_out !== 1'b1 || fabric_out !== 2'b10) begin
            bad++;
            $display("FAIL scan_e2 got=%b/%b exp=1/10", fabric_sc_out, fabric_out);
        end
        #2;
        fabric_reset = 1'b1;
        #1;
        total++;
        if (fabric_sc_out !== 1'b0 || fabric_out !== 2'b01) begin
            bad++;
            $display("FAIL scan_async_rst got=%b/%b exp=0/01", fabric_sc_out, fabric_out);
        end
        fabric_reset = 1'b0;
        Test_en      = 1'b0;
    endtask

`ifdef FABRIC_SYNC_CLEAR_EN
    task automatic test_sclr();
        do_reset();
        frac_logic_out = 2'b00;
        Test_en        = 1'b1;
        fabric_sc_in   = 1'b1;
        tick();
        tick();
        Test_en     = 1'b0;
        fabric_sclr = 1'b1;
        cfg_en      = 1'b1;
        tick();
        cfg_en      = 1'b0;
        fabric_sclr = 1'b0;
        total++;
        if (fabric_reg_out !== 1'b1) begin
            bad++;
            $display("FAIL sclr_cfg_en got=%b exp=1", fabric_reg_out);
        end
        load_cfg(8'b0100_0100);
        total++;
        if (fabric_out !== 2'b11) begin
            bad++;
            $display("FAIL sclr_preload got=%b exp=11", fabric_out);
        end
        Test_en     = 1'b1;
        fabric_sclr = 1'b1;
        tick();
        Test_en     = 1'b0;
        fabric_sclr = 1'b0;
        total++;
        if (fabric_out !== 2'b00 || fabric_sc_out !== 1'b0) begin
            bad++;
            $display("FAIL sclr_scan got=%b/%b exp=00/0", fabric_out, fabric_sc_out);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_cfg_chain();
        test_reg_chain();
        test_toggle();
        test_scan();
`ifdef FABRIC_SYNC_CLEAR_EN
        test_sclr();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
